// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl: packet-reception controller for the 1x3 router.
// Decodes the header address, selects a destination FIFO and sequences
// header/payload/parity writes, with full back-pressure and per-port soft reset.
// Optional feature macro: ROUTER_FSM_TIMEOUT_EN adds a WAIT_TILL_EMPTY timeout
// that abandons the packet and pulses timeout_drop.
module router_fsm_ctrl #(
  parameter int NUM_DEST    = 3,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_rst,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [1:0] fifo_sel,
  output logic       timeout_drop
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL
  } state_t;

  // The address code one past the last destination is never routable.
  localparam logic [1:0] INVALID_ADDR = 2'(NUM_DEST);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 31) begin : g_bad_timeout
    $error("router_fsm_ctrl: TIMEOUT_CYC must be in 1..31");
  end

  state_t state;
  state_t next_state;
  logic   hdr_ok;
  logic   sel_full;
  logic   sel_empty;
  logic   sel_soft_rst;
  logic   timeout_hit;

  // Once a packet is accepted, only the latched destination's flags matter.
  assign hdr_ok       = pkt_valid && (data_in != INVALID_ADDR);
  assign sel_full     = fifo_full[fifo_sel];
  assign sel_empty    = fifo_empty[fifo_sel];
  assign sel_soft_rst = soft_rst[fifo_sel];

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYC - 1);

  logic [4:0] wait_cnt;

  // Count cycles spent in WAIT_TILL_EMPTY; held at zero everywhere else so
  // every entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT_TILL_EMPTY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

  assign timeout_hit = (state == WAIT_TILL_EMPTY) && !sel_empty &&
                       (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic; a soft reset on the selected port overrides everything.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of
    // inferred latches when a case arm leaves next_state untouched.
    next_state = state;
    if ((state != DECODE_ADDRESS) && sel_soft_rst) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_ok) begin
            next_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty)        next_state = LOAD_FIRST_DATA;
          else if (timeout_hit) next_state = DECODE_ADDRESS;
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (sel_full)        next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          next_state = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        FIFO_FULL_STATE: begin
          if (!sel_full) next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) next_state = LOAD_PARITY;
          else                    next_state = LOAD_DATA;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // State, destination latch and outputs registered together; each output
  // is decoded from the state being entered so it lines up with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state         <= DECODE_ADDRESS;
      fifo_sel      <= '0;
      timeout_drop  <= 1'b0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == DECODE_ADDRESS) && (next_state != DECODE_ADDRESS)) begin
        fifo_sel <= data_in;
      end
      timeout_drop  <= timeout_hit && !sel_soft_rst;
      detect_add    <= (next_state == DECODE_ADDRESS);
      lfd_state     <= (next_state == LOAD_FIRST_DATA);
      ld_state      <= (next_state == LOAD_DATA);
      laf_state     <= (next_state == LOAD_AFTER_FULL);
      full_state    <= (next_state == FIFO_FULL_STATE);
      rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
      write_enb_reg <= (next_state == LOAD_DATA) ||
                       (next_state == LOAD_PARITY) ||
                       (next_state == LOAD_AFTER_FULL);
      busy          <= (next_state != DECODE_ADDRESS) &&
                       (next_state != LOAD_DATA);
    end
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb_router_fsm_ctrl: directed scoreboard bench for router_fsm_ctrl.
// Stimulus pushes the expected post-edge output vector; a monitor pops and
// compares one entry after each rising edge.
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_rst;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, timeout_drop;
  logic [1:0] fifo_sel;

  router_fsm_ctrl dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy),
    .fifo_sel(fifo_sel), .timeout_drop(timeout_drop)
  );

  always #5 clk = ~clk;

  typedef enum int {S_DA, S_WTE, S_LFD, S_LD, S_LP, S_CPE, S_FFS, S_LAF} st_e;
  typedef struct {
    logic [10:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [10:0] act_vec;
  assign act_vec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    write_enb_reg, rst_int_reg, busy, fifo_sel, timeout_drop};

  // Expected outputs per state, straight from the state/output table:
  // bits {detect, lfd, ld, laf, full, write_enb, rst_int, busy}.
  function automatic logic [10:0] outs(input st_e st, input logic [1:0] sel,
                                       input logic td);
    logic [7:0] f;
    case (st)
      S_DA:    f = 8'b1000_0000;
      S_WTE:   f = 8'b0000_0001;
      S_LFD:   f = 8'b0100_0001;
      S_LD:    f = 8'b0010_0100;
      S_LP:    f = 8'b0000_0101;
      S_CPE:   f = 8'b0000_0011;
      S_FFS:   f = 8'b0000_1001;
      S_LAF:   f = 8'b0001_0101;
      default: f = 8'b0000_0000;
    endcase
    return {f, sel, td};
  endfunction

  task automatic check(input string name, input logic [10:0] act,
                       input logic [10:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Queue the outputs expected after the coming edge, then move to the
  // next falling edge where the following inputs are driven.
  task automatic step(input st_e st, input logic [1:0] sel, input string name,
                      input logic td = 1'b0);
    exp_t e;
    e.vec  = outs(st, sel, td);
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare one queued expectation shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, act_vec, e.vec);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 3'b000;
    fifo_empty = 3'b111; soft_rst = 3'b000; parity_done = 1'b0;
    low_pkt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_async", act_vec, outs(S_DA, 2'd0, 1'b0));
    step(S_DA, 2'd0, "reset_hold");
    rst = 1'b0;
    step(S_DA, 2'd0, "idle_after_reset");

    // Header to port 1, payload, then parity and back to decode.
    pkt_valid = 1'b1; data_in = 2'd1;
    step(S_LFD, 2'd1, "t1_lfd");
    data_in = 2'd0;
    step(S_LD, 2'd1, "t1_first_write");
    step(S_LD, 2'd1, "t2_payload1");
    fifo_full = 3'b101;
    step(S_LD, 2'd1, "t2_other_full_ignored");
    fifo_full = 3'b000;
    step(S_LD, 2'd1, "t2_payload3");
    pkt_valid = 1'b0;
    step(S_LP, 2'd1, "t2_load_parity");
    step(S_CPE, 2'd1, "t2_check_parity");
    step(S_DA, 2'd1, "t2_back_to_decode");

    // Full back-pressure on port 1, resumed and finished by parity_done.
    pkt_valid = 1'b1; data_in = 2'd1;
    step(S_LFD, 2'd1, "t3a_lfd");
    step(S_LD, 2'd1, "t3a_ld");
    fifo_full = 3'b010;
    step(S_FFS, 2'd1, "t3a_full");
    step(S_FFS, 2'd1, "t3a_full_hold");
    fifo_full = 3'b000;
    step(S_LAF, 2'd1, "t3a_laf");
    parity_done = 1'b1; pkt_valid = 1'b0;
    step(S_DA, 2'd1, "t3a_parity_done");
    parity_done = 1'b0;

    // Port 0: LAF -> LD, LAF -> LP via low_pkt_valid, CPE -> full.
    pkt_valid = 1'b1; data_in = 2'd0;
    step(S_LFD, 2'd0, "t3b_lfd");
    step(S_LD, 2'd0, "t3b_ld");
    fifo_full = 3'b001;
    step(S_FFS, 2'd0, "t3b_full");
    fifo_full = 3'b000;
    step(S_LAF, 2'd0, "t3b_laf");
    step(S_LD, 2'd0, "t3b_laf_to_ld");
    fifo_full = 3'b001;
    step(S_FFS, 2'd0, "t3b_full_again");
    fifo_full = 3'b000; low_pkt_valid = 1'b1;
    step(S_LAF, 2'd0, "t3b_laf_again");
    step(S_LP, 2'd0, "t3b_laf_low_pkt");
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step(S_CPE, 2'd0, "t3b_check_parity");
    fifo_full = 3'b001;
    step(S_FFS, 2'd0, "t3b_cpe_full");
    fifo_full = 3'b000; parity_done = 1'b1; low_pkt_valid = 1'b1;
    step(S_LAF, 2'd0, "t3b_laf_final");
    step(S_DA, 2'd0, "t3b_parity_priority");
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Destination 2 not empty: wait, then proceed once it drains.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step(S_WTE, 2'd2, "t4_wait_enter");
    pkt_valid = 1'b0;
    for (int i = 0; i < 10; i++) step(S_WTE, 2'd2, "t4_wait_hold");
    fifo_empty = 3'b111;
    step(S_LFD, 2'd2, "t4_lfd_after_empty");
    step(S_LD, 2'd2, "t4_ld");
    step(S_LP, 2'd2, "t4_lp");
    step(S_CPE, 2'd2, "t4_cpe");
    step(S_DA, 2'd2, "t4_done");

    // Soft reset of the selected port while waiting.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step(S_WTE, 2'd2, "t5_wait_enter");
    pkt_valid = 1'b0; soft_rst = 3'b100;
    step(S_DA, 2'd2, "t5_soft_rst_wait");
    soft_rst = 3'b000;

    // Reset in the middle of a wait.
    pkt_valid = 1'b1; data_in = 2'd2;
    step(S_WTE, 2'd2, "rst_wait_enter");
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(S_WTE, 2'd2, "rst_wait_hold");
    rst = 1'b1;
    #1;
    check("rst_mid_wait_async", act_vec, outs(S_DA, 2'd0, 1'b0));
    step(S_DA, 2'd0, "rst_mid_wait_hold");
    rst = 1'b0;

`ifdef ROUTER_FSM_TIMEOUT_EN
    // Timeout after exactly 30 cycles in WAIT_TILL_EMPTY, one-cycle pulse.
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
    step(S_WTE, 2'd0, "t6_wait_enter");
    pkt_valid = 1'b0;
    for (int i = 0; i < 29; i++) step(S_WTE, 2'd0, "t6_wait_count");
    step(S_DA, 2'd0, "t6_timeout", 1'b1);
    step(S_DA, 2'd0, "t6_drop_one_cycle");
    // Count restarts on a fresh entry.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step(S_WTE, 2'd2, "t6_reenter");
    pkt_valid = 1'b0;
    for (int i = 0; i < 29; i++) step(S_WTE, 2'd2, "t6_recount");
    step(S_DA, 2'd2, "t6_timeout_again", 1'b1);
    step(S_DA, 2'd2, "t6_drop_clear");
    fifo_empty = 3'b111;
`else
    // Without the timeout the wait holds indefinitely and never drops.
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
    step(S_WTE, 2'd0, "t6_wait_enter");
    pkt_valid = 1'b0;
    for (int i = 0; i < 40; i++) step(S_WTE, 2'd0, "t6_no_timeout");
    soft_rst = 3'b001;
    step(S_DA, 2'd0, "t6_soft_rst_exit");
    soft_rst = 3'b000; fifo_empty = 3'b111;
`endif

    // Soft reset: other port ignored, selected port returns to decode.
    pkt_valid = 1'b1; data_in = 2'd0;
    step(S_LFD, 2'd0, "t5_lfd");
    step(S_LD, 2'd0, "t5_ld");
    soft_rst = 3'b010;
    step(S_LD, 2'd0, "t5_soft_other");
    soft_rst = 3'b001;
    step(S_DA, 2'd0, "t5_soft_sel");
    soft_rst = 3'b000; pkt_valid = 1'b0;
    step(S_DA, 2'd0, "t5_idle");
    // Invalid address 3 is ignored.
    pkt_valid = 1'b1; data_in = 2'd3;
    step(S_DA, 2'd0, "t5_addr3_ignored");
    step(S_DA, 2'd0, "t5_addr3_hold");
    // Soft reset has no effect while decoding.
    data_in = 2'd1; soft_rst = 3'b001;
    step(S_LFD, 2'd1, "t5_soft_in_decode");
    soft_rst = 3'b000; pkt_valid = 1'b0;
    step(S_LD, 2'd1, "t5_ld_final");
    step(S_LP, 2'd1, "t5_lp_final");
    step(S_CPE, 2'd1, "t5_cpe_final");
    step(S_DA, 2'd1, "t5_done");

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drained: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
Packet-reception controller for the 1x3 router. Decodes the header byte on the input bus, selects one of three destination FIFOs, and sequences header, payload and parity writes through the register stage into that FIFO. Handles destination-full back-pressure and per-port soft reset. Drives the FIFO's lfd_state input and the input register's write and parity-check controls.

Parameters:
NUM_DEST, 3, number of destination FIFOs; fixed at 3, address code 2'b11 is invalid
TIMEOUT_CYC, 30, WAIT_TILL_EMPTY timeout in clk cycles; used only with ROUTER_FSM_TIMEOUT_EN; range 1-31

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pkt_valid  input  1  input bus carries a valid packet byte
data_in  input  2  header address bits [1:0] of the input byte
fifo_full  input  3  full flag per destination FIFO
fifo_empty  input  3  empty flag per destination FIFO
soft_rst  input  3  per-destination soft reset (read-side timeout)
parity_done  input  1  input register has captured the parity byte
low_pkt_valid  input  1  pkt_valid fell while the FSM was stalled on full
detect_add  output  1  FSM in DECODE_ADDRESS
lfd_state  output  1  FSM in LOAD_FIRST_DATA (header write)
ld_state  output  1  FSM in LOAD_DATA
laf_state  output  1  FSM in LOAD_AFTER_FULL
full_state  output  1  FSM in FIFO_FULL_STATE
write_enb_reg  output  1  input register writes its byte to the selected FIFO
rst_int_reg  output  1  clear internal parity/error registers (CHECK_PARITY_ERROR)
busy  output  1  source must hold the current byte
fifo_sel  output  2  latched destination index, 0-2
timeout_drop  output  1  one-cycle pulse on WAIT_TILL_EMPTY timeout (0 unless ROUTER_FSM_TIMEOUT_EN)

Behaviour:
- Registered state only; all outputs except fifo_sel and timeout_drop decode from the current state (Moore). fifo_sel is a register.
- Reset (rst=1, async): state=DECODE_ADDRESS, fifo_sel=0, counter=0. detect_add=1; every other output 0.
- DECODE_ADDRESS: detect_add=1, busy=0.
  - pkt_valid && data_in!=3 && fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid && data_in!=3 && !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - Otherwise stay. A header with data_in=3 is ignored.
  - fifo_sel<=data_in on either exit.
- WAIT_TILL_EMPTY: busy=1. Goes to LOAD_FIRST_DATA when fifo_empty[fifo_sel]=1.
- LOAD_FIRST_DATA: lfd_state=1, busy=1, write_enb_reg=0. Unconditional -> LOAD_DATA.
- LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0. Transitions in priority order:
  - fifo_full[fifo_sel] -> FIFO_FULL_STATE.
  - !pkt_valid -> LOAD_PARITY.
  - Otherwise stay.
- LOAD_PARITY: write_enb_reg=1, busy=1. -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1.
  - fifo_full[fifo_sel] -> FIFO_FULL_STATE.
  - Otherwise -> DECODE_ADDRESS.
- FIFO_FULL_STATE: full_state=1, busy=1, write_enb_reg=0. Goes to LOAD_AFTER_FULL when !fifo_full[fifo_sel].
- LOAD_AFTER_FULL: laf_state=1, busy=1, write_enb_reg=1. Transitions in priority order:
  - parity_done -> DECODE_ADDRESS.
  - low_pkt_valid -> LOAD_PARITY.
  - Otherwise -> LOAD_DATA.
- Soft reset: soft_rst[fifo_sel]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS on the next edge, overriding all other transitions. soft_rst on a non-selected port is ignored.
- Full/empty flags of non-selected FIFOs never affect transitions after DECODE_ADDRESS.
- Reset mid-packet: immediate return to DECODE_ADDRESS. No partial-packet recovery.
- Latency: the header in DECODE_ADDRESS with an empty destination gives lfd_state=1 on the next cycle and the first write_enb_reg=1 on the cycle after that.

Optional Feature:
ROUTER_FSM_TIMEOUT_EN
- Defined: a 5-bit counter clears on entry to WAIT_TILL_EMPTY and increments each cycle in that state. When the counter reaches TIMEOUT_CYC-1 with the destination still not empty:
  - next state is DECODE_ADDRESS;
  - timeout_drop pulses 1 for one cycle (registered, aligned with the return to DECODE_ADDRESS).
- Not defined: no counter; WAIT_TILL_EMPTY holds indefinitely; timeout_drop tied to 0.

Test Plan:
1. Reset, then pkt_valid=1, data_in=2'b01, fifo_empty=3'b111 -> next cycle lfd_state=1, fifo_sel=1; cycle after: ld_state=1, write_enb_reg=1, busy=0.
2. 4-byte payload, then pkt_valid=0 -> LOAD_PARITY (write_enb_reg=1), then CHECK_PARITY_ERROR (rst_int_reg=1), then detect_add=1.
3. In LOAD_DATA, assert fifo_full[1]=1 -> full_state=1, busy=1, write_enb_reg=0. Deassert full -> laf_state=1. With parity_done=1 -> DECODE_ADDRESS; with low_pkt_valid=1 -> LOAD_PARITY.
4. Header data_in=2'b10 with fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1, held for 10 cycles. Set fifo_empty[2]=1 -> LOAD_FIRST_DATA next cycle.
5. In LOAD_DATA with fifo_sel=0: pulse soft_rst[1] -> no effect. Pulse soft_rst[0] -> detect_add=1 next cycle. Separately, header data_in=2'b11 -> stays in DECODE_ADDRESS.
6. With ROUTER_FSM_TIMEOUT_EN defined and TIMEOUT_CYC=30: hold fifo_empty[0]=0 in WAIT_TILL_EMPTY -> timeout_drop=1 for exactly one cycle after 30 cycles, with return to DECODE_ADDRESS. Assert rst mid-wait -> immediate detect_add=1 and counter cleared.
